// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag bit positions and pin constants for the 4-bit ALU
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    // Bit positions of the status flags on uio_out
    localparam int FLAG_ZERO  = 3;
    localparam int FLAG_CARRY = 4;
    localparam int FLAG_DBZ   = 5;
    localparam int FLAG_NEG   = 6;
    localparam int FLAG_VALID = 7;

    localparam logic [7:0] UIO_OE = 8'b1111_1000;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - pin bundle between the chip wrapper and the ALU block
interface alu_if;

    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

endinterface

// File: rtl/alu_div4.sv
// rtl/alu_div4.sv - combinational 4-bit unsigned restoring divider
module alu_div4 (
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);

    logic [4:0] part;
    logic [3:0] quo;

    always_comb begin
        part = '0;
        quo  = '0;
        for (int i = 3; i >= 0; i--) begin
            part = {part[3:0], dividend[i]};
            if (part >= {1'b0, divisor}) begin
                part   = part - {1'b0, divisor};
                quo[i] = 1'b1;
            end
        end
    end

    // A zero divisor yields all-ones in both fields so the packed result reads 8'hFF
    assign div_by_zero = (divisor == 4'd0);
    assign quotient    = div_by_zero ? 4'hF : quo;
    assign remainder   = div_by_zero ? 4'hF : part[3:0];

endmodule

// File: rtl/alu_top.sv
// rtl/alu_top.sv - registered 4-bit ALU with status flags on the bidirectional pins
module alu_top
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [2:0] op;
    logic [3:0] div_q;
    logic [3:0] div_r;
    logic       div_z;

    logic [7:0] res;
    logic       carry;
    logic       dbz;

    logic       zero_q;
    logic       carry_q;
    logic       dbz_q;
    logic       valid_q;

    wire unused_uio = &{1'b0, uio_in[7:3]};

    assign a  = ui_in[7:4];
    assign b  = ui_in[3:0];
    assign a8 = {4'b0, a};
    assign b8 = {4'b0, b};
    assign op = uio_in[2:0];

    alu_div4 u_div (
        .dividend    (a),
        .divisor     (b),
        .quotient    (div_q),
        .remainder   (div_r),
        .div_by_zero (div_z)
    );

    always_comb begin
        res   = '0;
        carry = 1'b0;
        dbz   = 1'b0;
        case (op)
            OP_ADD: begin
                res   = a8 + b8;
                carry = res[4];
            end
            OP_SUB: begin
                res   = a8 - b8;
                carry = (a < b);
            end
            OP_AND: res = a8 & b8;
            OP_OR:  res = a8 | b8;
            OP_XOR: res = a8 ^ b8;
            OP_NOT: res = ~ui_in;
            OP_MUL: res = a8 * b8;
            OP_DIV: begin
                res = {div_r, div_q};
                dbz = div_z;
            end
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_out  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            dbz_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            uo_out  <= res;
            zero_q  <= (res == 8'd0);
            carry_q <= carry;
            dbz_q   <= dbz;
            valid_q <= 1'b1;
        end
    end

    // Negative mirrors the registered result MSB, so it clears with it in reset
    always_comb begin
        uio_out             = '0;
        uio_out[FLAG_ZERO]  = zero_q;
        uio_out[FLAG_CARRY] = carry_q;
        uio_out[FLAG_DBZ]   = dbz_q;
        uio_out[FLAG_NEG]   = uo_out[7];
        uio_out[FLAG_VALID] = valid_q;
    end

    assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_alu_top.sv
// tb/tb_alu_top.sv - vector table, random model comparison and reset sequences for alu_top
module tb_alu_top;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    alu_if pins ();

    alu_top dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ui_in   (pins.ui_in),
        .uio_in  (pins.uio_in),
        .uo_out  (pins.uo_out),
        .uio_out (pins.uio_out),
        .uio_oe  (pins.uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ui;
        logic [2:0] op;
        logic [7:0] uo;
        logic       z;
        logic       c;
        logic       d;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] ui, input logic [2:0] op);
        int a;
        int b;
        int r;
        logic c;
        logic d;
        logic [7:0] uo;
        a = int'(ui[7:4]);
        b = int'(ui[3:0]);
        r = 0;
        c = 1'b0;
        d = 1'b0;
        case (op)
            3'd0: begin r = a + b; c = (r > 15); end
            3'd1: begin r = (a - b) & 255; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = 255 - int'(ui);
            3'd6: r = a * b;
            default: begin
                if (b == 0) begin r = 255; d = 1'b1; end
                else r = (a % b) * 16 + a / b;
            end
        endcase
        uo = r[7:0];
        return {uo, 1'b1, uo[7], d, c, (uo == 8'd0), 3'b000};
    endfunction

    task automatic drive(input logic [7:0] ui, input logic [2:0] op);
        pins.ui_in  = ui;
        pins.uio_in = {5'($urandom), op};
    endtask

    logic [15:0] expq[$];
    logic [15:0] e;

    initial begin
        vecs.push_back('{8'h12, 3'd0, 8'h03, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'hF1, 3'd0, 8'h10, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h43, 3'd1, 8'h01, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h35, 3'd1, 8'hFE, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'hCA, 3'd2, 8'h08, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h69, 3'd3, 8'h0F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h78, 3'd4, 8'h0F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h5D, 3'd5, 8'hA2, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'hAA, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h32, 3'd6, 8'h06, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 3'd6, 8'hE1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h28, 3'd7, 8'h20, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h93, 3'd7, 8'h03, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h90, 3'd7, 8'hFF, 1'b0, 1'b0, 1'b1});

        // Reset held with live inputs
        drive(8'h12, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_uo", pins.uo_out, 8'h00);
        chk("reset_uio", pins.uio_out, 8'h00);
        chk("reset_oe", pins.uio_oe, 8'hF8);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("pre_edge_uio", pins.uio_out, 8'h00);
        @(posedge clk);
        #1;
        chk("first_uo", pins.uo_out, 8'h03);
        chk("first_valid", {7'b0, pins.uio_out[7]}, 8'h01);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ui, vecs[i].op);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_uo", i), pins.uo_out, vecs[i].uo);
            chk($sformatf("vec%0d_uio", i), pins.uio_out,
                {1'b1, vecs[i].uo[7], vecs[i].d, vecs[i].c, vecs[i].z, 3'b000});
        end

        // Back-to-back random ops, each result checked one cycle after issue
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("rand_uo", pins.uo_out, e[15:8]);
                chk("rand_uio", pins.uio_out, e[7:0]);
            end
            drive(8'($urandom), 3'($urandom));
            expq.push_back(model(pins.ui_in, pins.uio_in[2:0]));
        end
        @(negedge clk);
        e = expq.pop_front();
        chk("rand_last_uo", pins.uo_out, e[15:8]);
        chk("rand_last_uio", pins.uio_out, e[7:0]);

        // Reset pulsed mid-stream while a nonzero result is held
        drive(8'h00, 3'd5);
        @(posedge clk);
        #1;
        chk("pre_pulse_uo", pins.uo_out, 8'hFF);
        drive(8'h35, 3'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("pulse_uo", pins.uo_out, 8'h00);
        chk("pulse_uio", pins.uio_out, 8'h00);
        chk("pulse_oe", pins.uio_oe, 8'hF8);
        @(posedge clk);
        #1;
        chk("pulse_hold_uo", pins.uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_pulse_uo", pins.uo_out, 8'hFE);
        chk("post_pulse_uio", pins.uio_out, 8'hD0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_top.md
# alu_top

Small registered 4-bit ALU built as a Tiny Tapeout-style user block. It takes two 4-bit operands packed in `ui_in` and a 3-bit opcode on `uio_in[2:0]`. It returns an 8-bit registered result on `uo_out` and status flags on the upper bidirectional pins. It sits directly behind the chip-level pin wrapper and has no handshake.

## Interface
Parameters: none.

Ports:
- `clk`  input  1  – single system clock; all state updates on its rising edge.
- `rst_n`  input  1  – reset, asynchronous and active-low.
- `ui_in`  input  8  – operands: A = `ui_in[7:4]`, B = `ui_in[3:0]` (unsigned).
- `uio_in`  input  8  – `uio_in[2:0]` is the opcode; `uio_in[7:3]` is ignored.
- `uo_out`  output  8  – registered result.
- `uio_out`  output  8  – `[2:0]` = 0; `[3]` zero; `[4]` carry/borrow; `[5]` div-by-zero; `[6]` negative (= `uo_out[7]`); `[7]` valid.
- `uio_oe`  output  8  – constant `8'b1111_1000` (bits 7:3 driven, bits 2:0 inputs).

## Operation
Opcodes and results. A and B are zero-extended to 8 bits before arithmetic.
- 000 ADD: `uo_out` = A+B (0..30); carry = bit 4 of the sum.
- 001 SUB: `uo_out` = (A−B) mod 256, two's complement; borrow = (A<B).
- 010 AND: `{4'b0, A&B}`.
- 011 OR: `{4'b0, A|B}`.
- 100 XOR: `{4'b0, A^B}`.
- 101 NOT: `~ui_in`, a full 8-bit invert of both operands.
- 110 MUL: `uo_out` = A*B (0..225), unsigned 8-bit, no overflow possible.
- 111 DIV, B≠0: `uo_out[3:0]` = A/B (quotient), `uo_out[7:4]` = A%B (remainder).
- 111 DIV, B=0: `uo_out` = `8'hFF` and div-by-zero = 1.

Flags:
- Carry/borrow is 0 for every opcode except ADD and SUB.
- Div-by-zero is 0 for every opcode except DIV with B=0.
- Zero = (registered result == 0). For DIV by zero it is 0.
- Negative = `uo_out[7]` for every opcode.
- Valid = 0 in reset; set to 1 at the first rising clock edge after `rst_n` deasserts, then stays 1.

## Timing
- Result and flags are computed combinationally from `ui_in` and `uio_in`. They are captured into output registers on the rising edge of `clk`, giving 1-cycle latency.
- Inputs must be stable around the rising edge. A new operation may be issued every cycle; there is no stall.
- While `rst_n`=0, asynchronously: `uo_out`=0 and `uio_out`=0, including the valid flag. `uio_oe` keeps its constant value during reset.
- Reset asserted mid-operation discards the pending result immediately.
- The first update after release happens at the first rising edge with `rst_n`=1.
- Opcode bits `uio_in[7:3]` never affect behaviour.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams: `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_XOR`, `OP_NOT`, `OP_MUL`, `OP_DIV`;
  - flag bit-index constants;
  - the `UIO_OE` constant.
- One sub-module, `alu_div4`: a combinational 4-bit unsigned restoring divider.
  - Inputs: dividend, divisor. Outputs: quotient, remainder, `div_by_zero`.
  - It returns quotient=`4'hF`, remainder=`4'hF` when the divisor is 0.
- The top contains the opcode mux, flag logic and output registers.

## Test plan
Drive inputs on the falling edge and check outputs after the next rising edge.
- Reset: `rst_n`=0 with arbitrary inputs → `uo_out`=0 and `uio_out`=0 asynchronously, `uio_oe`=`8'hF8`. After release plus one edge, valid=1.
- ADD and SUB:
  - `ui_in`=`8'h12`, op 000 → `uo_out`=`8'h03`, carry=0.
  - `ui_in`=`8'hF1`, op 000 → `uo_out`=`8'h10`, carry=1.
  - `ui_in`=`8'h43`, op 001 → `8'h01`.
  - `ui_in`=`8'h35`, op 001 → `8'hFE`, borrow=1, negative=1.
- Logic:
  - `8'hCA` AND → `8'h08`.
  - `8'h69` OR → `8'h0F`.
  - `8'h78` XOR → `8'h0F`.
  - `8'h5D` NOT → `8'hA2`.
  - `8'hAA` XOR → `8'h00` with zero=1.
- MUL:
  - `8'h32` → `8'h06`.
  - `8'hFF` → `8'hE1`.
- DIV:
  - `8'h28` → `8'h20` (quotient 0, remainder 2).
  - `8'h93` → `8'h03`.
  - `8'h90` → `8'hFF` with div-by-zero=1 and zero=0.
- Pipelining and reset:
  - Back-to-back ops on consecutive cycles → each result appears exactly one cycle later.
  - `rst_n` pulsed low mid-stream → outputs clear immediately and valid drops.
